// File: rtl/alarm_timer.sv
// ============================================================================
// Module   : alarm_timer
// Purpose  : Programmable countdown timer for the anti-theft alarm controller.
//            Holds four reprogrammable delays, loads one on request, counts it
//            down on the 1 Hz enable and returns a one-cycle expiry pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_timer #(
    parameter int WIDTH             = 4,
    parameter int T_ARM_DELAY       = 6,
    parameter int T_DRIVER_DELAY    = 8,
    parameter int T_PASSENGER_DELAY = 15,
    parameter int T_ALARM_ON        = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_timer,
    input  logic [1:0]       interval,
    input  logic             one_hz_enable,
    input  logic             reprogram,
    input  logic [1:0]       time_param_sel,
    input  logic [WIDTH-1:0] time_value,
    output logic             expired,
    output logic             busy,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_param [4];
    logic [WIDTH-1:0] w_load_val;

    assign w_load_val = r_param[interval];

    // Parameter file: a write strobe always wins and is stored verbatim.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_param[0] <= WIDTH'(T_ARM_DELAY);
            r_param[1] <= WIDTH'(T_DRIVER_DELAY);
            r_param[2] <= WIDTH'(T_PASSENGER_DELAY);
            r_param[3] <= WIDTH'(T_ALARM_ON);
        end else if (reprogram) begin
            r_param[time_param_sel] <= time_value;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Reprogram and abort both park the timer in IDLE with a cleared count.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (reprogram || !start_timer) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_count_nxt = w_load_val;
                    w_state_nxt = (w_load_val != '0) ? S_COUNT : S_EXPIRED;
                end
                S_COUNT: begin
                    if (one_hz_enable) begin
                        if (r_count > C_ONE) begin
                            w_count_nxt = r_count - C_ONE;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = S_EXPIRED;
                        end
                    end
                end
                S_EXPIRED: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign expired   = (r_state == S_EXPIRED);
    assign busy      = (r_state == S_COUNT);
    assign remaining = r_count;

endmodule

`default_nettype wire

// File: doc/alarm_timer.md
# alarm_timer

Programmable countdown timer for the anti-theft alarm. Holds the four reprogrammable delay parameters, loads the one selected by the controller's `interval` code when `start_timer` is raised, and counts it down on the 1 Hz enable. When the count reaches zero it returns a one-cycle `expired` pulse to the controller. It sits directly downstream of the alarm control FSM, consumes its `start_timer`/`interval` outputs, and produces the FSM's `expired` input.

## Interface

- `WIDTH`, 4: width of parameter registers and down-counter, in seconds.
- `T_ARM_DELAY`, 6: reset value of parameter 00, the arming delay.
- `T_DRIVER_DELAY`, 8: reset value of parameter 01, the driver-door delay.
- `T_PASSENGER_DELAY`, 15: reset value of parameter 10, the passenger-door delay.
- `T_ALARM_ON`, 10: reset value of parameter 11, the siren-on duration.

- `clock`  in  1: system clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start_timer`  in  1: level request from the FSM. Low means abort or idle.
- `interval`  in  2: parameter select, sampled only on load.
- `one_hz_enable`  in  1: one-clock tick, once per second.
- `reprogram`  in  1: write strobe for the parameter registers.
- `time_param_sel`  in  2: selects the parameter to write.
- `time_value`  in  WIDTH: value to write.
- `expired`  out  1: one-cycle pulse when the countdown completes.
- `busy`  out  1: high while in COUNT.
- `remaining`  out  WIDTH: current down-counter value.

## Operation

- Parameter file: `param[0..3]` of WIDTH bits each.
  - Reset loads T_ARM_DELAY, T_DRIVER_DELAY, T_PASSENGER_DELAY and T_ALARM_ON.
  - On a clock edge with `reprogram`=1: `param[time_param_sel]` <= `time_value`. All values 0..2^WIDTH-1 are stored unchanged, including 0.
- States: IDLE, COUNT, EXPIRED.
  - Encoding is free. Unused encodings go to IDLE.
- Priority at every edge, from highest to lowest:
  1. `reprogram`
  2. `start_timer`=0
  3. normal transition
- `reprogram`=1: next state IDLE and `count` <= 0 from any state, in addition to the parameter write. This matches the FSM returning to ARMED.
- `start_timer`=0 in any state: next state IDLE, `count` <= 0.
- IDLE with `start_timer`=1:
  - `count` <= `param[interval]`.
  - Next state is COUNT if that value is nonzero, otherwise EXPIRED.
  - A `one_hz_enable` on the load edge is ignored.
- COUNT with `one_hz_enable`=1:
  - If `count` > 1: `count` <= `count` - 1.
  - If `count` == 1: `count` <= 0 and next state EXPIRED.
- COUNT with `one_hz_enable`=0: hold.
- `interval` changes during COUNT are ignored. The value latched at load stands.
- EXPIRED: next state IDLE unconditionally. The `start_timer`=0 and `reprogram` rules give the same result.
  - If `start_timer` is still high, IDLE reloads on the following edge from the then-current `interval`. This is the TRIGGERED→ACTIVATE_ALARM and the ACTIVATE_ALARM re-arm path.
- Outputs are Moore, decoded from registers only:
  - `expired` = (state==EXPIRED)
  - `busy` = (state==COUNT)
  - `remaining` = `count`
- Reset values: state IDLE, `count` 0, `expired` 0, `busy` 0, `remaining` 0, parameters at their defaults.

## Timing

- Load latency: with `start_timer` rising before edge E0, the state is COUNT and `remaining`=N after E0.
- Expiry: if the Nth tick after E0 is sampled at edge Ek, `expired`=1 for exactly the one cycle after Ek. `remaining`=0 during that cycle.
- Zero parameter: `expired`=1 in the cycle after E0, with no tick needed.
- Restart: with `start_timer` held high, the reload happens at E_{k+1}, so there is one IDLE cycle between the expiry pulse and the next COUNT.
- `expired` is never high on two consecutive cycles.
- An abort (`start_timer`=0) takes effect at the next edge. A `start_timer` dropping while in EXPIRED does not suppress the pulse already on the output.
- `reset` asserted mid-count: all outputs go to their reset values immediately, without waiting for a clock edge, and parameters revert to their defaults.
- `reprogram` and `start_timer` rising together: the write happens, the state stays IDLE, and the load occurs on the next edge using the new value.

## Test plan

- Defaults: `interval`=01, `start_timer` held high, ticks every 10 clocks → `remaining` 8,7,…,1. `expired` pulses for 1 cycle after the 8th tick, then reloads to 8.
- Reprogram: `reprogram` with sel=10, value=3, then `start_timer` with `interval`=10 → `expired` after the 3rd tick. After reset, `param[2]` is back to 15.
- Abort: `interval`=11, drop `start_timer` after 4 ticks → IDLE, `remaining`=0, no `expired` pulse. A restart loads 10.
- Zero and chaining: program `param[1]`=0, start with `interval`=01 → `expired` in the cycle after the load edge. Then switch to `interval`=11 with start held → IDLE for one cycle, then `remaining`=10.
- Tick on the load edge and `interval` change mid-count: the tick coincident with the load is not counted. Changing `interval` from 01 to 10 after 2 ticks still expires after 8 total ticks.
- Async reset mid-count (`remaining`=5) → all outputs 0 immediately. The next start with `interval`=00 counts 6 ticks.
